// File: rtl/irq_ctrl_multi.sv
`default_nettype none
// ============================================================================
// irq_ctrl_multi : multi-channel IRQ / NMI / reset arbiter with vector select
// Revision       : 1.0
// ============================================================================
module irq_ctrl_multi #(
  parameter int         NUM_IRQ      = 4,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] RESET_VEC_LO = 8'hFC,
  parameter logic [7:0] NMI_VEC_LO   = 8'hFA,
  parameter logic [7:0] IRQ_VEC_BASE = 8'hFE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic               sync,
  input  logic               i_flag,
  input  logic               vector_ack,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               nmi,
  output logic               intg,
  output logic               nmig,
  output logic               resp,
  output logic [7:0]         vector_lo,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam int W = NUM_IRQ + 1;

  state_t             state, state_nxt;
  logic               nmig_nxt;
  logic [2:0]         id_nxt;
  logic [7:0]         vec_nxt;

  logic [W-1:0]       sync_pipe [SYNC_STAGES];
  logic [W-1:0]       synced;
  logic [W-1:0]       prev;
  logic [W-1:0]       rise;
  logic               nmi_lat;
  logic [NUM_IRQ-1:0] edge_lat;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] clr_irq;
  logic               service_ack;
  logic               clr_nmi;
  logic               req;
  logic [2:0]         win_id;
  logic [7:0]         win_vec;

  // Bit NUM_IRQ of the pipeline carries NMI, lower bits carry the IRQ lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
      prev <= '0;
    end else begin
      sync_pipe[0] <= {nmi, irq_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      prev <= synced;
    end
  end

  assign synced      = sync_pipe[SYNC_STAGES-1];
  assign rise        = synced & ~prev;
  assign service_ack = (state == ST_SERVICE) & vector_ack & ready;
  assign clr_nmi     = service_ack & nmig;

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_chan
    assign clr_irq[k] = service_ack & ~nmig & (irq_id == 3'(k));
    assign pending[k] = irq_edge_mode[k] ? edge_lat[k] : synced[k];
  end

  // Latch set is not qualified by ready, and a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_lat  <= 1'b0;
      edge_lat <= '0;
    end else begin
      nmi_lat  <= rise[NUM_IRQ] | (nmi_lat & ~clr_nmi);
      edge_lat <= (rise[NUM_IRQ-1:0] & irq_edge_mode) | (edge_lat & ~clr_irq);
    end
  end

  assign irq_pending = pending & irq_enable;
  assign req         = nmi_lat | ((|irq_pending) & ~i_flag);

  always_comb begin
    win_id = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_pending[k]) win_id = 3'(k);
    end
  end

  assign win_vec = IRQ_VEC_BASE - {4'b0000, win_id, 1'b0};

  always_comb begin
    state_nxt = state;
    nmig_nxt  = nmig;
    id_nxt    = irq_id;
    vec_nxt   = vector_lo;
    case (state)
      ST_RESET: begin
        vec_nxt = RESET_VEC_LO;
        if (vector_ack & ready) begin
          state_nxt = ST_IDLE;
          vec_nxt   = IRQ_VEC_BASE;
        end
      end
      ST_IDLE: begin
        vec_nxt = IRQ_VEC_BASE;
        if (sync & ready & req) begin
          state_nxt = ST_SERVICE;
          if (nmi_lat) begin
            nmig_nxt = 1'b1;
            id_nxt   = 3'd0;
            vec_nxt  = NMI_VEC_LO;
          end else begin
            nmig_nxt = 1'b0;
            id_nxt   = win_id;
            vec_nxt  = win_vec;
          end
        end
      end
      ST_SERVICE: begin
        if (service_ack) begin
          state_nxt = ST_IDLE;
          nmig_nxt  = 1'b0;
          vec_nxt   = IRQ_VEC_BASE;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        vec_nxt   = RESET_VEC_LO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RESET;
      nmig      <= 1'b0;
      irq_id    <= 3'd0;
      vector_lo <= RESET_VEC_LO;
    end else begin
      state     <= state_nxt;
      nmig      <= nmig_nxt;
      irq_id    <= id_nxt;
      vector_lo <= vec_nxt;
    end
  end

  assign intg = (state == ST_SERVICE);
  assign resp = (state == ST_RESET);

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_multi.sv
`default_nettype none
// ============================================================================
// tb_irq_ctrl_multi : directed + randomized bench for irq_ctrl_multi
// Revision          : 1.0
// ============================================================================
module tb_irq_ctrl_multi;
  localparam int         N  = 4;
  localparam int         SS = 2;
  localparam logic [7:0] RV = 8'hFC;
  localparam logic [7:0] NV = 8'hFA;
  localparam logic [7:0] IB = 8'hFE;

  logic         clk = 1'b0;
  logic         reset, ready, sync, i_flag, vector_ack, nmi;
  logic [N-1:0] irq_in, irq_edge_mode, irq_enable;
  logic         intg, nmig, resp;
  logic [7:0]   vector_lo;
  logic [2:0]   irq_id;
  logic [N-1:0] irq_pending;

  int checks = 0;
  int errors = 0;

  irq_ctrl_multi #(
    .NUM_IRQ(N), .SYNC_STAGES(SS), .RESET_VEC_LO(RV), .NMI_VEC_LO(NV), .IRQ_VEC_BASE(IB)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .sync(sync), .i_flag(i_flag),
    .vector_ack(vector_ack), .irq_in(irq_in), .irq_edge_mode(irq_edge_mode),
    .irq_enable(irq_enable), .nmi(nmi), .intg(intg), .nmig(nmig), .resp(resp),
    .vector_lo(vector_lo), .irq_id(irq_id), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample history (newest first), latches and service status.
  logic [N:0] m_hist[$];
  logic [N:0] m_prev;
  bit         m_nmi_lat;
  bit [N-1:0] m_edge;
  bit         m_resetting, m_busy, m_is_nmi;
  int         m_chan;
  logic [7:0] m_vec;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SS; i++) m_hist.push_front('0);
    m_prev      = '0;
    m_nmi_lat   = 1'b0;
    m_edge      = '0;
    m_resetting = 1'b1;
    m_busy      = 1'b0;
    m_is_nmi    = 1'b0;
    m_chan      = 0;
    m_vec       = RV;
  endtask

  function automatic logic [N-1:0] exp_pending();
    logic [N:0]   s = m_hist[SS-1];
    logic [N-1:0] p;
    for (int k = 0; k < N; k++)
      p[k] = irq_enable[k] & (irq_edge_mode[k] ? m_edge[k] : s[k]);
    return p;
  endfunction

  function automatic int lowest_set(input logic [N-1:0] p);
    for (int k = 0; k < N; k++) if (p[k]) return k;
    return 0;
  endfunction

  task automatic model_clock();
    logic [N:0]   s    = m_hist[SS-1];
    logic [N:0]   rise = s & ~m_prev;
    logic [N-1:0] p    = exp_pending();
    bit           ack  = vector_ack && ready;
    bit           done = m_busy && ack;
    bit           n_nmi;
    bit [N-1:0]   n_edge;
    n_nmi = rise[N] || (m_nmi_lat && !(done && m_is_nmi));
    for (int k = 0; k < N; k++)
      n_edge[k] = (rise[k] && irq_edge_mode[k]) ||
                  (m_edge[k] && !(done && !m_is_nmi && m_chan == k));
    if (m_resetting) begin
      if (ack) begin
        m_resetting = 1'b0;
        m_vec       = IB;
      end
    end else if (m_busy) begin
      if (ack) begin
        m_busy   = 1'b0;
        m_is_nmi = 1'b0;
        m_vec    = IB;
      end
    end else if (sync && ready && (m_nmi_lat || (p != 0 && !i_flag))) begin
      m_busy = 1'b1;
      if (m_nmi_lat) begin
        m_is_nmi = 1'b1;
        m_vec    = NV;
      end else begin
        m_is_nmi = 1'b0;
        m_chan   = lowest_set(p);
        m_vec    = 8'(IB - 2 * m_chan);
      end
    end
    m_nmi_lat = n_nmi;
    m_edge    = n_edge;
    m_hist.push_front({nmi, irq_in});
    void'(m_hist.pop_back());
    m_prev = s;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("resp",        {7'b0, resp}, {7'b0, m_resetting});
    chk("intg",        {7'b0, intg}, {7'b0, m_busy});
    chk("nmig",        {7'b0, nmig}, {7'b0, m_is_nmi});
    chk("vector_lo",   vector_lo, m_vec);
    chk("irq_pending", 8'(irq_pending), 8'(exp_pending()));
    if (m_busy && !m_is_nmi) chk("irq_id", {5'b0, irq_id}, 8'(m_chan));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_clock();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ready = 1'b1; sync = 1'b0; i_flag = 1'b0; vector_ack = 1'b0;
    nmi = 1'b0; irq_in = '0; irq_edge_mode = '0; irq_enable = '1;
    model_reset();
    steps(2);
    chk("reset_resp", {7'b0, resp}, 8'h01);
    chk("reset_vec",  vector_lo, RV);
    reset = 1'b0;
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    chk("reset_exit_resp", {7'b0, resp}, 8'h00);

    // Priority: NMI beats level channels 1 and 3, then channel 1 wins.
    irq_in = 4'b1010; nmi = 1'b1;
    steps(4);
    sync = 1'b1; step(); sync = 1'b0;
    chk("prio_intg", {7'b0, intg}, 8'h01);
    chk("prio_nmig", {7'b0, nmig}, 8'h01);
    chk("prio_vec",  vector_lo, 8'hFA);
    vector_ack = 1'b1; step(); vector_ack = 1'b0; nmi = 1'b0;
    sync = 1'b1; step(); sync = 1'b0;
    chk("prio2_intg", {7'b0, intg}, 8'h01);
    chk("prio2_id",   {5'b0, irq_id}, 8'h01);
    chk("prio2_vec",  vector_lo, 8'hFC);
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    irq_in = '0; steps(3);

    // Masking: edge channel 2 latched while i_flag masks it.
    i_flag = 1'b1; irq_edge_mode = 4'b0100;
    irq_in = 4'b0100; step(); irq_in = '0;
    steps(3);
    sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mask_pend", 8'(irq_pending), 8'h04);
      chk("mask_intg", {7'b0, intg}, 8'h00);
    end
    i_flag = 1'b0; step(); sync = 1'b0;
    chk("mask_take_vec", vector_lo, 8'hFA);
    chk("mask_take_id",  {5'b0, irq_id}, 8'h02);
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    chk("mask_cleared", 8'(irq_pending), 8'h00);
    irq_edge_mode = '0;

    // Freeze: channel 3 in service, channel 0 arrives, channel 3 drops.
    irq_in = 4'b1000; steps(3);
    sync = 1'b1; step(); sync = 1'b0;
    chk("frz_vec", vector_lo, 8'hF8);
    irq_in = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("frz_hold_vec", vector_lo, 8'hF8);
      chk("frz_hold_id",  {5'b0, irq_id}, 8'h03);
    end
    irq_in = 4'b0001; steps(3);
    chk("frz_level_drop_id", {5'b0, irq_id}, 8'h03);
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    sync = 1'b1; step(); sync = 1'b0;
    chk("frz_next_id",  {5'b0, irq_id}, 8'h00);
    chk("frz_next_vec", vector_lo, 8'hFE);
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    irq_in = '0; steps(3);

    // Edge race: second NMI edge coincides with ack of the first NMI.
    nmi = 1'b1; steps(4);
    sync = 1'b1; step(); sync = 1'b0;
    chk("race_nmig1", {7'b0, nmig}, 8'h01);
    nmi = 1'b0; steps(3);
    nmi = 1'b1; steps(2);
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    chk("race_ack_intg", {7'b0, intg}, 8'h00);
    sync = 1'b1; step(); sync = 1'b0;
    chk("race_nmig2", {7'b0, nmig}, 8'h01);
    chk("race_vec2",  vector_lo, NV);
    vector_ack = 1'b1; step(); vector_ack = 1'b0; nmi = 1'b0;
    steps(3);

    // ready stall with vector_ack held high.
    irq_in = 4'b0010; steps(3);
    sync = 1'b1; step(); sync = 1'b0;
    ready = 1'b0; vector_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_intg", {7'b0, intg}, 8'h01);
      chk("stall_vec",  vector_lo, 8'hFC);
    end
    ready = 1'b1; step(); vector_ack = 1'b0;
    chk("stall_done", {7'b0, intg}, 8'h00);
    irq_in = '0; steps(3);

    // Asynchronous reset in the middle of a service.
    irq_in = 4'b0001; steps(3);
    sync = 1'b1; step(); sync = 1'b0;
    chk("mid_intg", {7'b0, intg}, 8'h01);
    #2; reset = 1'b1; model_reset(); #1;
    chk("async_resp", {7'b0, resp}, 8'h01);
    chk("async_vec",  vector_lo, RV);
    chk("async_intg", {7'b0, intg}, 8'h00);
    steps(2); reset = 1'b0; irq_in = '0;
    vector_ack = 1'b1; step(); vector_ack = 1'b0;
    chk("async_exit_resp", {7'b0, resp}, 8'h00);

    // Randomized traffic against the model.
    irq_edge_mode = N'($urandom);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ N'($urandom);
      if ($urandom_range(0, 5) == 0) nmi = ~nmi;
      if ($urandom_range(0, 30) == 0) irq_enable = N'($urandom);
      sync       = ($urandom_range(0, 2) == 0);
      ready      = ($urandom_range(0, 3) != 0);
      vector_ack = ($urandom_range(0, 2) == 0);
      i_flag     = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl_multi.md
Name: irq_ctrl_multi

Overview:
- Parametrised successor to the single-IRQ/NMI interrupt control used by the cpu6502 core.
- Accepts NUM_IRQ independent maskable sources (per-channel level or edge mode, per-channel enable), one NMI, and reset.
- Arbitrates the sources, raises the take-interrupt strobes at instruction boundaries, and supplies a per-source vector low byte to the address mux, so one core can serve multiple vectored peripherals.

Parameters:
- NUM_IRQ, 4: number of maskable channels, 1..8.
- SYNC_STAGES, 2: input synchroniser flops on irq_in/nmi, 1..3.
- RESET_VEC_LO, 8'hFC: vector low byte for reset.
- NMI_VEC_LO, 8'hFA: vector low byte for NMI.
- IRQ_VEC_BASE, 8'hFE: channel k vector low byte is IRQ_VEC_BASE - 2*k (8-bit, wraps).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- ready, input, 1: CPU ready; all state advances are qualified by ready, except reset and the synchroniser/edge-detect pipeline.
- sync, input, 1: opcode fetch cycle (instruction boundary).
- i_flag, input, 1: P register I bit; 1 masks all IRQ channels.
- vector_ack, input, 1: CPU is fetching the vector low byte this cycle.
- irq_in, input, NUM_IRQ: raw interrupt requests, active-high.
- irq_edge_mode, input, NUM_IRQ: 1 = rising-edge latched, 0 = level.
- irq_enable, input, NUM_IRQ: per-channel enable.
- nmi, input, 1: raw NMI, active-high, rising-edge sensitive.
- intg, output, 1: interrupt taken; the CPU forces BRK.
- nmig, output, 1: taken interrupt is the NMI.
- resp, output, 1: reset sequence in progress; the CPU suppresses writes.
- vector_lo, output, 8: vector low byte for the current/next vector fetch.
- irq_id, output, 3: channel being serviced (valid when intg & ~nmig).
- irq_pending, output, NUM_IRQ: per-channel pending state after enable, before i_flag masking.

Behaviour:
- Reset (asynchronous):
  - state = RESET, resp = 1, intg = 0, nmig = 0, vector_lo = RESET_VEC_LO, irq_id = 0.
  - All edge latches, NMI latch and synchronisers cleared.
  - Edge detector "previous" values load 0, so a source already high after reset counts as an edge.
- Synchronisers: irq_in and nmi pass through SYNC_STAGES flops, clocked every cycle regardless of ready.
- Edge detection: on the synchronised signal, compared with its registered previous value.
- NMI latch:
  - Set on a synced rising edge.
  - Cleared on vector_ack & ready while state = SERVICE & nmig.
  - A new edge in that same cycle wins: the latch stays set.
- Channel k pending:
  - Edge mode: latch set on a synced rising edge, cleared on vector_ack & ready while servicing k. Set wins over a simultaneous clear.
  - Level mode: equals the synced level.
  - irq_pending[k] = pending_k & irq_enable[k].
  - Disabling a channel masks it but does not clear its edge latch.
- Request: req = nmi_latch | (|irq_pending & ~i_flag).
- Priority: reset > NMI > lowest-index enabled pending channel.
- FSM states:
  - RESET: resp = 1. Exit to IDLE on vector_ack & ready; resp drops the next cycle.
  - IDLE: when sync & ready & req, capture the winner (nmig, irq_id, vector_lo) and go to SERVICE with intg = 1 the next cycle. Otherwise vector_lo = IRQ_VEC_BASE, for software BRK.
  - SERVICE: intg = 1. Winner frozen; later higher-priority arrivals do not retarget. On vector_ack & ready: clear the serviced latch, intg = 0, nmig = 0, vector_lo = IRQ_VEC_BASE, go to IDLE.
- Latency: a source edge becomes visible at edge detection SYNC_STAGES+1 cycles after the input changes; it is taken at the first later sync & ready.
- ready low: the FSM and latches hold, apart from edge-latch setting.
- Level source deasserting during SERVICE: service still completes; the id stays frozen.
- Width: irq_id is zero-extended to 3 bits. The vector is computed mod 256.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-SERVICE, release, then pulse vector_ack with ready = 1.
  - Required: resp = 1 and vector_lo = FC immediately at reset assertion; resp = 0 the cycle after the ack.
- Priority:
  - Stimulus: i_flag = 0, irq_in = 4'b1010 (level), nmi rises the same cycle, then sync.
  - Required: intg = 1, nmig = 1, vector_lo = FA. After ack and the next sync: intg = 1, irq_id = 1, vector_lo = FC.
- Masking:
  - Stimulus: i_flag = 1, edge-mode channel 2 pulses for 1 cycle; later i_flag = 0 and sync.
  - Required: irq_pending[2] = 1 throughout; taken with vector_lo = FA (FE - 4); irq_pending[2] = 0 after the ack.
- Freeze:
  - Stimulus: servicing channel 3 (vector F8), channel 0 raised during SERVICE.
  - Required: vector_lo stays F8 until the ack; channel 0 is taken at the next sync.
- Edge race:
  - Stimulus: NMI rising edge in the same cycle as the vector_ack of a prior NMI service.
  - Required: NMI latch stays set; second NMI taken at the next sync.
- ready stall:
  - Stimulus: ready = 0 for 5 cycles during SERVICE with vector_ack held high.
  - Required: no state change; completes on the first cycle with ready = 1.
